// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU execute stage.
//   alu_op_e  : ALU operation encoding (matches aluControlEE)
//   FWD_*     : forward-select encodings for the operand muxes
package cpu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6,
        ALU_MOV = 3'd7
    } alu_op_e;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU of the execute stage.
// Ports:
//   op_a, op_b  : operands
//   alu_op      : operation select
//   result      : result truncated to WIDTH
//   flag_n/z/v/c: next values for the condition flags
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  alu_op_e          alu_op,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_c
);

    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] diff_ext;
    logic [3:0]     shamt;

    // Subtraction as A + ~B + 1 so the carry out is the "no borrow" flag.
    assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
    assign diff_ext = {1'b0, op_a} + {1'b0, ~op_b} + (WIDTH+1)'(1);
    assign shamt    = op_b[3:0];

    always_comb begin
        result = '0;
        flag_v = 1'b0;
        flag_c = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                result = sum_ext[WIDTH-1:0];
                flag_c = sum_ext[WIDTH];
                flag_v = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                         (result[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_SUB: begin
                result = diff_ext[WIDTH-1:0];
                flag_c = diff_ext[WIDTH];
                flag_v = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                         (result[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_AND: result = op_a & op_b;
            ALU_OR:  result = op_a | op_b;
            ALU_XOR: result = op_a ^ op_b;
            ALU_SHL: result = op_a << shamt;
            ALU_SHR: result = op_a >> shamt;
            ALU_MOV: result = op_b;
            default: result = '0;
        endcase
    end

    assign flag_n = result[WIDTH-1];
    assign flag_z = (result == '0);

endmodule

// File: rtl/cpu_execute.sv
// Execute stage: operand forwarding, immediate select, ALU and flag register.
// Ports:
//   clk, rst_n               : clock, async active-low reset (flags only)
//   aluControlEE             : ALU operation
//   data2SelectorEE          : operand B = immediate (1) or forwarded reg2 (0)
//   data1/2ForwardSelectorE  : 0/3 register, 1 WB forward, 2 MEM forward
//   reg1/2ContentE, inmmediateE, forwardM, forwardWB : data inputs
//   aluOutputE               : combinational ALU result
//   N, Z, V, C               : registered condition flags
module cpu_execute
    import cpu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       aluControlEE,
    input  logic             data2SelectorEE,
    input  logic [1:0]       data1ForwardSelectorE,
    input  logic [1:0]       data2ForwardSelectorE,
    input  logic [WIDTH-1:0] reg1ContentE,
    input  logic [WIDTH-1:0] reg2ContentE,
    input  logic [WIDTH-1:0] inmmediateE,
    input  logic [WIDTH-1:0] forwardM,
    input  logic [WIDTH-1:0] forwardWB,
    output logic [WIDTH-1:0] aluOutputE,
    output logic             N,
    output logic             Z,
    output logic             V,
    output logic             C
);

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] reg2_fwd;
    logic [WIDTH-1:0] op_b;
    logic             alu_n, alu_z, alu_v, alu_c;
    logic [3:0]       flags_d;
    logic [3:0]       flags_q;   // {N, Z, V, C}

    // A case (not a ?: chain) keeps unselected X inputs out of the result.
    always_comb begin
        op_a = reg1ContentE;
        case (data1ForwardSelectorE)
            FWD_WB:  op_a = forwardWB;
            FWD_MEM: op_a = forwardM;
            default: op_a = reg1ContentE;
        endcase

        reg2_fwd = reg2ContentE;
        case (data2ForwardSelectorE)
            FWD_WB:  reg2_fwd = forwardWB;
            FWD_MEM: reg2_fwd = forwardM;
            default: reg2_fwd = reg2ContentE;
        endcase

        op_b = data2SelectorEE ? inmmediateE : reg2_fwd;
    end

    cpu_alu #(.WIDTH(WIDTH)) u_alu (
        .op_a   (op_a),
        .op_b   (op_b),
        .alu_op (alu_op_e'(aluControlEE)),
        .result (aluOutputE),
        .flag_n (alu_n),
        .flag_z (alu_z),
        .flag_v (alu_v),
        .flag_c (alu_c)
    );

    always_comb begin
        flags_d = {alu_n, alu_z, alu_v, alu_c};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign N = flags_q[3];
    assign Z = flags_q[2];
    assign V = flags_q[1];
    assign C = flags_q[0];

endmodule

// File: tb/tb_cpu_execute.sv
// Self-checking bench for cpu_execute: scoreboard of expected flags, one task per scenario.
module tb_cpu_execute;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  aluControlEE;
    logic        data2SelectorEE;
    logic [1:0]  data1ForwardSelectorE;
    logic [1:0]  data2ForwardSelectorE;
    logic [15:0] reg1ContentE, reg2ContentE, inmmediateE, forwardM, forwardWB;
    logic [15:0] aluOutputE;
    logic        N, Z, V, C;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [15:0] r;
        logic        n, z, v, c;
    } exp_t;

    exp_t sb_q[$];

    cpu_execute #(.WIDTH(16)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .aluControlEE          (aluControlEE),
        .data2SelectorEE       (data2SelectorEE),
        .data1ForwardSelectorE (data1ForwardSelectorE),
        .data2ForwardSelectorE (data2ForwardSelectorE),
        .reg1ContentE          (reg1ContentE),
        .reg2ContentE          (reg2ContentE),
        .inmmediateE           (inmmediateE),
        .forwardM              (forwardM),
        .forwardWB             (forwardWB),
        .aluOutputE            (aluOutputE),
        .N                     (N),
        .Z                     (Z),
        .V                     (V),
        .C                     (C)
    );

    always #5 clk = ~clk;

    // Reference model built from integer arithmetic rather than bit tricks.
    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int ua, ub, sa, sb, full, sfull;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        e.v = 1'b0;
        e.c = 1'b0;
        e.r = 16'h0;
        case (op)
            3'd0: begin
                full  = ua + ub;
                e.r   = full[15:0];
                e.c   = (full > 65535);
                sfull = sa + sb;
                e.v   = (sfull > 32767) || (sfull < -32768);
            end
            3'd1: begin
                full  = ua - ub;
                e.r   = full[15:0];
                e.c   = (ua >= ub);
                sfull = sa - sb;
                e.v   = (sfull > 32767) || (sfull < -32768);
            end
            3'd2: e.r = a & b;
            3'd3: e.r = a | b;
            3'd4: e.r = a ^ b;
            3'd5: begin
                full = ua * (1 << int'(b[3:0]));
                e.r  = full[15:0];
            end
            3'd6: begin
                full = ua / (1 << int'(b[3:0]));
                e.r  = full[15:0];
            end
            default: e.r = b;
        endcase
        e.n = e.r[15];
        e.z = (e.r == 16'h0);
        return e;
    endfunction

    function automatic logic [15:0] pick(input logic [1:0] sel, input logic [15:0] rc,
                                         input logic [15:0] wb, input logic [15:0] m);
        if (sel == 2'd1) return wb;
        if (sel == 2'd2) return m;
        return rc;
    endfunction

    // Drive one operation, push its expectation and check the combinational result.
    task automatic apply(input string name, input logic [2:0] op,
                         input logic [1:0] sa, input logic [1:0] sb, input logic dsel,
                         input logic [15:0] r1, input logic [15:0] r2, input logic [15:0] imm,
                         input logic [15:0] fm, input logic [15:0] fwb);
        logic [15:0] a, b;
        exp_t e;
        aluControlEE          = op;
        data1ForwardSelectorE = sa;
        data2ForwardSelectorE = sb;
        data2SelectorEE       = dsel;
        reg1ContentE          = r1;
        reg2ContentE          = r2;
        inmmediateE           = imm;
        forwardM              = fm;
        forwardWB             = fwb;
        a = pick(sa, r1, fwb, fm);
        b = dsel ? imm : pick(sb, r2, fwb, fm);
        e = model(op, a, b);
        sb_q.push_back(e);
        #1;
        tests_run++;
        if (aluOutputE !== e.r) begin
            tests_failed++;
            $display("FAIL %s result: got %h expected %h", name, aluOutputE, e.r);
        end
    endtask

    // Clock the flags in and compare against the oldest expectation.
    task automatic tick_check(input string name);
        exp_t e;
        @(posedge clk);
        #1;
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s flags: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            if ({N, Z, V, C} !== {e.n, e.z, e.v, e.c}) begin
                tests_failed++;
                $display("FAIL %s flags NZVC: got %b expected %b", name, {N, Z, V, C},
                         {e.n, e.z, e.v, e.c});
            end
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if ({N, Z, V, C} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 0000", {N, Z, V, C});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        apply("add", 3'd0, 2'd0, 2'd0, 1'b0, 16'd4, 16'd4, 16'h0, 16'h0, 16'h0);
        tests_run++;
        if (aluOutputE !== 16'd8) begin
            tests_failed++;
            $display("FAIL add_const: got %h expected 0008", aluOutputE);
        end
        tick_check("add");
    endtask

    task automatic test_forward_wb();
        // forwardM left X: it is not selected and must not leak into the result.
        apply("fwd_wb", 3'd1, 2'd1, 2'd0, 1'b0, 16'd0, 16'd2, 16'h0, 16'hxxxx, 16'd8);
        tests_run++;
        if (aluOutputE !== 16'd6) begin
            tests_failed++;
            $display("FAIL fwd_wb_const: got %h expected 0006", aluOutputE);
        end
        tick_check("fwd_wb");
    endtask

    task automatic test_forward_mem_imm();
        apply("fwd_mem_imm", 3'd3, 2'd2, 2'd0, 1'b1, 16'h1234, 16'h5555, 16'h0F0F, 16'h00F0, 16'hAAAA);
        reg2ContentE          = 16'hFFFF;
        forwardWB             = 16'hxxxx;
        data2ForwardSelectorE = 2'd1;
        #1;
        tests_run++;
        if (aluOutputE !== 16'h0FFF) begin
            tests_failed++;
            $display("FAIL imm_ignores_reg2: got %h expected 0fff", aluOutputE);
        end
        tick_check("fwd_mem_imm");
        // Selector 3 behaves like the register path.
        apply("sel3", 3'd0, 2'd3, 2'd3, 1'b0, 16'h0010, 16'h0020, 16'h0, 16'hxxxx, 16'hxxxx);
        tick_check("sel3");
    endtask

    task automatic test_zero_carry();
        apply("sub_eq", 3'd1, 2'd0, 2'd0, 1'b0, 16'd5, 16'd5, 16'h0, 16'h0, 16'h0);
        tick_check("sub_eq");
        apply("add_wrap", 3'd0, 2'd0, 2'd0, 1'b0, 16'hFFFF, 16'h0001, 16'h0, 16'h0, 16'h0);
        tests_run++;
        if ({aluOutputE, 1'b0} !== 17'h0) begin
            tests_failed++;
            $display("FAIL add_wrap_const: got %h expected 0000", aluOutputE);
        end
        tick_check("add_wrap");
        apply("sub_borrow", 3'd1, 2'd0, 2'd0, 1'b0, 16'd3, 16'd7, 16'h0, 16'h0, 16'h0);
        tick_check("sub_borrow");
    endtask

    task automatic test_overflow();
        apply("sub_ovf", 3'd1, 2'd0, 2'd0, 1'b0, 16'h8000, 16'h0001, 16'h0, 16'h0, 16'h0);
        tests_run++;
        if (aluOutputE !== 16'h7FFF) begin
            tests_failed++;
            $display("FAIL sub_ovf_const: got %h expected 7fff", aluOutputE);
        end
        tick_check("sub_ovf");
        apply("add_ovf", 3'd0, 2'd0, 2'd0, 1'b0, 16'h7FFF, 16'h0001, 16'h0, 16'h0, 16'h0);
        tick_check("add_ovf");
    endtask

    task automatic test_logic_shift();
        apply("and", 3'd2, 2'd0, 2'd0, 1'b0, 16'hF0F0, 16'hFF00, 16'h0, 16'h0, 16'h0);
        tick_check("and");
        apply("xor", 3'd4, 2'd0, 2'd0, 1'b0, 16'hA5A5, 16'hFFFF, 16'h0, 16'h0, 16'h0);
        tick_check("xor");
        apply("shl0", 3'd5, 2'd0, 2'd0, 1'b1, 16'hBEEF, 16'h0, 16'h0000, 16'h0, 16'h0);
        tick_check("shl0");
        apply("shl15", 3'd5, 2'd0, 2'd0, 1'b1, 16'h0003, 16'h0, 16'h000F, 16'h0, 16'h0);
        tests_run++;
        if (aluOutputE !== 16'h8000) begin
            tests_failed++;
            $display("FAIL shl15_const: got %h expected 8000", aluOutputE);
        end
        tick_check("shl15");
        apply("shr15", 3'd6, 2'd0, 2'd0, 1'b1, 16'hC000, 16'h0, 16'h000F, 16'h0, 16'h0);
        tick_check("shr15");
        apply("shr_hi_bits", 3'd6, 2'd0, 2'd0, 1'b1, 16'h8000, 16'h0, 16'hFFF3, 16'h0, 16'h0);
        tick_check("shr_hi_bits");
        apply("mov", 3'd7, 2'd0, 2'd0, 1'b1, 16'h1111, 16'h0, 16'h0000, 16'h0, 16'h0);
        tick_check("mov");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            apply("b2b", 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom));
            tick_check("b2b");
        end
    endtask

    task automatic test_async_reset();
        apply("pre_rst", 3'd0, 2'd0, 2'd0, 1'b0, 16'h7FFF, 16'h0001, 16'h0, 16'h0, 16'h0);
        tick_check("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({N, Z, V, C} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL async_clear: got %b expected 0000", {N, Z, V, C});
        end
        tests_run++;
        if (aluOutputE !== 16'h8000) begin
            tests_failed++;
            $display("FAIL rst_alu_out: got %h expected 8000", aluOutputE);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if ({N, Z, V, C} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL held_in_reset: got %b expected 0000", {N, Z, V, C});
        end
        rst_n = 1'b1;
        sb_q.push_back(model(3'd0, 16'h7FFF, 16'h0001));
        tick_check("post_rst");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n                 = 1'b0;
        aluControlEE          = 3'd0;
        data2SelectorEE       = 1'b0;
        data1ForwardSelectorE = 2'd0;
        data2ForwardSelectorE = 2'd0;
        reg1ContentE          = 16'h0;
        reg2ContentE          = 16'h0;
        inmmediateE           = 16'h0;
        forwardM              = 16'h0;
        forwardWB             = 16'h0;
        #1;
        test_reset();
        test_add();
        test_forward_wb();
        test_forward_mem_imm();
        test_zero_carry();
        test_overflow();
        test_logic_shift();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cpu_execute.md
Name: cpu_execute

Overview:
Execute stage of the 16-bit pipelined CPU. It selects each ALU operand from the register file value or a forwarded value (MEM or WB stage), and optionally replaces operand B with the immediate. It performs one of eight ALU operations combinationally. The N/Z/V/C condition flags are registered on the clock for later conditional instructions.

Parameters:
WIDTH, 16, datapath width in bits (operands, immediate, result).

Ports:
clk  input  1  system clock; flag register updates on the rising edge.
rst_n  input  1  asynchronous reset, active-low (one clock, async active-low reset; this is fixed).
aluControlEE  input  3  ALU operation select.
data2SelectorEE  input  1  ALU operand B source: 0 = forwarded reg2, 1 = immediate.
data1ForwardSelectorE  input  2  operand A source select.
data2ForwardSelectorE  input  2  reg2 path source select.
reg1ContentE  input  WIDTH  register file read data 1.
reg2ContentE  input  WIDTH  register file read data 2.
inmmediateE  input  WIDTH  sign/zero-extended immediate, already extended by decode.
forwardM  input  WIDTH  result forwarded from the MEM stage.
forwardWB  input  WIDTH  result forwarded from the WB stage.
aluOutputE  output  WIDTH  ALU result (combinational).
N  output  1  registered negative flag.
Z  output  1  registered zero flag.
V  output  1  registered signed-overflow flag.
C  output  1  registered carry flag.

Behaviour:
- Forward mux, same for A and the reg2 path:
  - selector 0: register content.
  - selector 1: forwardWB.
  - selector 2: forwardM.
  - selector 3: register content.
- Operand B = data2SelectorEE ? inmmediateE : forwarded reg2.
- ALU, purely combinational, result truncated to WIDTH:
  - 0 ADD: A+B.
  - 1 SUB: A-B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SHL: A << B[3:0].
  - 6 SHR logical: A >> B[3:0].
  - 7 MOV: result = B.
- aluOutputE follows input changes in the same cycle. It has zero latency and does not depend on clk or rst_n.
- Next-flag computation:
  - N = result[WIDTH-1].
  - Z = (result == 0).
  - ADD: C = carry out of bit WIDTH-1; V = A,B same sign and result sign differs.
  - SUB: C = 1 when no borrow (A >= B unsigned); V = A,B differ in sign and result sign differs from A.
  - Ops 2-7: C = 0, V = 0.
- Flag register: N/Z/V/C capture the next-flag values on every rising clk edge. There is no enable.
- rst_n low: N/Z/V/C clear to 0 immediately, asynchronously, and stay 0 while low.
  - Release is synchronous in effect: the first capture happens on the first rising edge with rst_n high.
  - Reset asserted mid-operation clears the flags at once; aluOutputE is unaffected.
- Any X/undriven forward input that is not selected must not affect the result.
- Shift amounts of 0 pass A unchanged. Shifts of 15 keep only the 1 surviving bit.

Decomposition:
- Shared package cpu_pkg:
  - typedef enum of ALU ops: ALU_ADD=0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_MOV.
  - forward-select constants: FWD_REG=0, FWD_WB=1, FWD_MEM=2.
- One natural sub-module: cpu_alu. It is combinational: operands, op → result plus next N/Z/V/C.
- The forward muxes, operand-B mux and flag register stay in cpu_execute.

Test Plan:
- Plain ADD: reg1=4, reg2=4, op=0, all selectors 0 → aluOutputE=8 immediately. After the next rising edge, N=0, Z=0, V=0, C=0.
- RAW from WB: reg1=0 (stale), forwardWB=8, reg2=2, op=1, selA=1, selB=0, data2Sel=0 → aluOutputE=6. After the edge, C=1, Z=0.
- Forward from MEM plus immediate: forwardM=0x00F0 on selA=2, inmmediateE=0x0F0F, data2Sel=1, op=3 (OR) → aluOutputE=0x0FFF. Changing reg2/forward on B has no effect.
- Zero/carry: SUB with A=5, B=5 → result 0, Z=1, C=1 after the edge. ADD with A=0xFFFF, B=1 → result 0, Z=1, C=1, V=0.
- Signed overflow: ADD 0x7FFF+0x0001 → 0x8000, N=1, V=1, C=0. SUB 0x8000-0x0001 → 0x7FFF, V=1.
- Reset: with flags set (N=1,V=1), drive rst_n low mid-cycle → flags 0 without waiting for a clock edge. aluOutputE unchanged. After rst_n high, flags update on the next rising edge.
